// File: rtl/test_slot_sched_pkg.sv
// Shared types and helpers for the test slot scheduler.
package test_slot_sched_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, GAP} sched_state_t;

    localparam int WDOG_W = 32;

    // Index width never drops below one bit, even for a single requester.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/test_slot_scheduler_rr_pick.sv
// Round-robin winner selection: the first set request at or after ptr, wrapping.
module rr_pick
    import test_slot_sched_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]            req,
    input  logic [idx_width(N_REQ)-1:0] ptr,
    output logic [idx_width(N_REQ)-1:0] winner,
    output logic                        valid
);

    localparam int W  = idx_width(N_REQ);
    localparam int CW = W + 1;

    logic [CW-1:0] cand;

    // Walk the requests in rotated order; the first hit wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr} + CW'(i);
            if (cand >= CW'(N_REQ)) begin
                cand = cand - CW'(N_REQ);
            end
            if (!valid && req[cand[W-1:0]]) begin
                valid  = 1'b1;
                winner = cand[W-1:0];
            end
        end
    end

endmodule

// File: rtl/test_slot_scheduler.sv
// Round-robin slot scheduler with watchdog for nested tests sharing one DUT.
// Optional grant statistics ports when TEST_SLOT_SCHEDULER_STATS_EN is defined.
module test_slot_scheduler
    import test_slot_sched_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int GAP_CYCLES     = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0]            done,
    output logic [N_REQ-1:0]            grant,
    output logic [idx_width(N_REQ)-1:0] active_idx,
    output logic                        busy,
    output logic                        timeout,
    output logic [idx_width(N_REQ)-1:0] timeout_idx,
    output logic [N_REQ-1:0]            served,
    output logic                        all_done
`ifdef TEST_SLOT_SCHEDULER_STATS_EN
    ,
    output logic [31:0]                 grant_cycles,
    output logic [31:0]                 max_hold
`endif
);

    localparam int                W         = idx_width(N_REQ);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]        GAP_LAST  = 4'(GAP_CYCLES - 1);

    sched_state_t      state, next_state;
    logic [W-1:0]      ptr, win_idx;
    logic              win_valid;
    logic [WDOG_W-1:0] wdog_cnt;
    logic [3:0]        gap_cnt;
    logic              done_hit, abandon, expire, release_now, timeout_fire;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (win_idx),
        .valid  (win_valid)
    );

    // Release priority: done beats abandon, abandon beats watchdog expiry.
    assign done_hit     = done[active_idx];
    assign abandon      = !req[active_idx];
    assign expire       = (TIMEOUT_CYCLES != 0) && (wdog_cnt == WDOG_LAST);
    assign release_now  = (state == GRANT) && (done_hit || abandon || expire);
    assign timeout_fire = (state == GRANT) && expire && !done_hit && !abandon;

    assign busy     = (state == GRANT);
    assign grant    = busy ? ({{(N_REQ-1){1'b0}}, 1'b1} << active_idx) : '0;
    assign all_done = &served;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (win_valid) next_state = GRANT;
            GRANT:   if (release_now) next_state = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:     if (gap_cnt == GAP_LAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_idx  <= '0;
            ptr         <= '0;
            wdog_cnt    <= '0;
            gap_cnt     <= '0;
            timeout     <= 1'b0;
            timeout_idx <= '0;
            served      <= '0;
        end else begin
            timeout <= timeout_fire;
            if (state == IDLE && win_valid) begin
                active_idx <= win_idx;
                wdog_cnt   <= '0;
            end
            if (state == GRANT && wdog_cnt != '1) begin
                wdog_cnt <= wdog_cnt + WDOG_W'(1);
            end
            if (state == GAP) begin
                gap_cnt <= gap_cnt + 4'd1;
            end
            if (release_now) begin
                ptr     <= (active_idx == W'(N_REQ - 1)) ? '0 : active_idx + W'(1);
                gap_cnt <= '0;
                if (done_hit || timeout_fire) begin
                    served[active_idx] <= 1'b1;
                end
                if (timeout_fire) begin
                    timeout_idx <= active_idx;
                end
            end
        end
    end

`ifdef TEST_SLOT_SCHEDULER_STATS_EN
    logic [31:0] hold_len;

    // The watchdog counter doubles as the length of the current grant.
    assign hold_len = (wdog_cnt == '1) ? wdog_cnt : wdog_cnt + 32'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cycles <= '0;
            max_hold     <= '0;
        end else begin
            if (busy && grant_cycles != '1) begin
                grant_cycles <= grant_cycles + 32'd1;
            end
            if (release_now && hold_len > max_hold) begin
                max_hold <= hold_len;
            end
        end
    end
`endif

endmodule

// File: tb/tb_test_slot_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level model.
module tb_test_slot_scheduler;
    import test_slot_sched_pkg::*;

    localparam int N = 4;
    localparam int T = 10;
    localparam int G = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req, done, grant, served;
    logic [1:0]   active_idx, timeout_idx;
    logic         busy, timeout, all_done;
`ifdef TEST_SLOT_SCHEDULER_STATS_EN
    logic [31:0]  grant_cycles, max_hold;
`endif

    always #5 clk = ~clk;

    test_slot_scheduler #(.N_REQ(N), .TIMEOUT_CYCLES(T), .GAP_CYCLES(G)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .active_idx  (active_idx),
        .busy        (busy),
        .timeout     (timeout),
        .timeout_idx (timeout_idx),
        .served      (served),
`ifdef TEST_SLOT_SCHEDULER_STATS_EN
        .grant_cycles(grant_cycles),
        .max_hold    (max_hold),
`endif
        .all_done    (all_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: who owns the slot, how long it has held it, idle cycles left before arbitration.
    int           m_owner, m_hold, m_wait, m_ptr, m_last, m_to_idx, m_rel_idx;
    bit           m_timeout;
    logic [N-1:0] m_served;
    longint       m_gcycles, m_maxhold;

    logic [N-1:0] pending;
    int           order[$];
    bit           saw_timeout;
    int           saw_to_idx, cyc, grant_cyc, to_cyc;
    logic         prev_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_hold    = 0;
        m_wait    = 0;
        m_ptr     = 0;
        m_last    = 0;
        m_to_idx  = 0;
        m_rel_idx = -1;
        m_timeout = 1'b0;
        m_served  = '0;
        m_gcycles = 0;
        m_maxhold = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic [N-1:0] d);
        bit found;
        int c;
        m_timeout = 1'b0;
        m_rel_idx = -1;
        if (m_owner >= 0) begin
            m_hold++;
            m_gcycles++;
            if (d[m_owner] || !r[m_owner] || (T != 0 && m_hold == T)) begin
                if (d[m_owner]) begin
                    m_served[m_owner] = 1'b1;
                end else if (r[m_owner]) begin
                    m_timeout = 1'b1;
                    m_to_idx  = m_owner;
                    m_served[m_owner] = 1'b1;
                end
                if (m_hold > m_maxhold) m_maxhold = m_hold;
                m_rel_idx = m_owner;
                m_ptr     = (m_owner + 1) % N;
                m_owner   = -1;
                m_wait    = G;
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else begin
            found = 1'b0;
            for (int i = 0; i < N; i++) begin
                c = (m_ptr + i) % N;
                if (!found && r[c]) begin
                    found   = 1'b1;
                    m_owner = c;
                    m_last  = c;
                    m_hold  = 0;
                end
            end
        end
    endtask

    task automatic check_output();
        chk("grant", 32'(grant), (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0);
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("active_idx", 32'(active_idx), 32'(m_last));
        chk("timeout", 32'(timeout), 32'(m_timeout));
        if (m_timeout) chk("timeout_idx", 32'(timeout_idx), 32'(m_to_idx));
        chk("served", 32'(served), 32'(m_served));
        chk("all_done", 32'(all_done), 32'(&m_served));
`ifdef TEST_SLOT_SCHEDULER_STATS_EN
        chk("grant_cycles", grant_cycles, 32'(m_gcycles));
        chk("max_hold", max_hold, 32'(m_maxhold));
`endif
        if (busy && !prev_busy) begin
            order.push_back(int'(active_idx));
            grant_cyc = cyc;
        end
        if (timeout) begin
            saw_timeout = 1'b1;
            saw_to_idx  = int'(timeout_idx);
            to_cyc      = cyc;
        end
        prev_busy = busy;
    endtask

    task automatic apply_stimulus(input logic [N-1:0] r, input logic [N-1:0] d);
        req  = r;
        done = d;
        @(posedge clk);
        model_edge(r, d);
        cyc++;
        #1;
        check_output();
        if (m_rel_idx >= 0) pending[m_rel_idx] = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        pending   = '0;
        prev_busy = 1'b0;
        #1 check_output();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Requesters in pending hold req; the owner pulses done after hold_len cycles.
    task automatic run_auto(input int hold_len, input logic [N-1:0] spur, input int max_cycles);
        logic [N-1:0] d;
        int k;
        k = 0;
        while (pending != '0 && k < max_cycles) begin
            d = '0;
            if (m_owner >= 0) begin
                if (m_hold == hold_len - 1) d[m_owner] = 1'b1;
                d = d | (spur & ~(4'b0001 << m_owner));
            end
            apply_stimulus(pending, d);
            k++;
        end
        chk("drain", 32'(pending), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) apply_stimulus('0, '0);
    endtask

    task automatic rand_phase(input int n);
        logic [N-1:0] d;
        int r;
        for (int k = 0; k < n; k++) begin
            if (k == n / 2) do_reset();
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && $urandom_range(0, 3) == 0) pending[i] = 1'b1;
            end
            d = '0;
            if (m_owner >= 0) begin
                r = int'($urandom_range(0, 99));
                if (r < 15) d[m_owner] = 1'b1;
                else if (r < 19) pending[m_owner] = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) d[$urandom_range(0, N - 1)] = 1'b1;
            apply_stimulus(pending, d);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        done      = '0;
        pending   = '0;
        cyc       = 0;
        grant_cyc = 0;
        to_cyc    = 0;
        saw_to_idx  = 0;
        saw_timeout = 1'b0;
        prev_busy   = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 check_output();
        #2 rst_n = 1'b1;

        // Reset while requester 0 holds the slot.
        apply_stimulus(4'b0001, '0);
        apply_stimulus(4'b0001, '0);
        chk("t1_granted", 32'(grant), 32'b0001);
        do_reset();
        chk("t1_grant_dropped", 32'(grant), 32'd0);
        idle_cycles(2);

        // Everyone requests, each holds for 5 cycles.
        order.delete();
        pending = 4'b1111;
        run_auto(5, '0, 200);
        chk("t2_all_done", 32'(all_done), 32'd1);
        chk("t2_count", 32'(order.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_order", (order.size() > i) ? 32'(order[i]) : 32'hffff, 32'(i));
        end
        idle_cycles(4);

        // Requester 2 never finishes and is cut off by the watchdog.
        saw_timeout = 1'b0;
        pending = 4'b0100;
        run_auto(0, '0, 100);
        chk("t3_timeout_seen", 32'(saw_timeout), 32'd1);
        chk("t3_timeout_idx", 32'(saw_to_idx), 32'd2);
        chk("t3_latency", 32'(to_cyc - grant_cyc), 32'd10);
        chk("t3_served2", 32'(served[2]), 32'd1);
        idle_cycles(4);

        // done lands on the expiry cycle.
        saw_timeout = 1'b0;
        pending = 4'b0010;
        run_auto(T, '0, 100);
        idle_cycles(1);
        chk("t4_no_timeout", 32'(saw_timeout), 32'd0);
        chk("t4_served1", 32'(served[1]), 32'd1);
        idle_cycles(4);

        // Move the pointer to 3, then check wrap-around with a stray done[1].
        pending = 4'b0100;
        run_auto(3, '0, 50);
        idle_cycles(4);
        order.delete();
        pending = 4'b1001;
        run_auto(4, 4'b0010, 100);
        chk("t5_first", (order.size() > 0) ? 32'(order[0]) : 32'hffff, 32'd3);
        chk("t5_second", (order.size() > 1) ? 32'(order[1]) : 32'hffff, 32'd0);
        idle_cycles(4);

        // Requester 1 walks away mid-grant.
        do_reset();
        for (int k = 0; k < 20 && !(m_owner == 1 && m_hold == 3); k++) begin
            apply_stimulus(4'b0010, '0);
        end
        chk("t6_holding", 32'(busy), 32'd1);
        apply_stimulus('0, '0);
        chk("t6_released", 32'(busy), 32'd0);
        chk("t6_not_served", 32'(served[1]), 32'd0);
        idle_cycles(4);

        pending = '0;
        rand_phase(800);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
